gemm_sequencer: RTL

Instruction-driven controller for `systolic_array_top`. It accepts 16-bit instructions (LD / ST / GEMM / DRAINSYS) over a valid/ready handshake and drives everything the array needs from outside:
- `ctrl_state`
- the top, left and down SRAM read windows
- the down-buffer readout port

It sits between the instruction reader and `systolic_array_top`, replacing hand-sequenced stimulus.

---
 rtl/gemm_pkg.sv | 30 +++
 rtl/gemm_sequencer_decode.sv | 30 +++
 rtl/gemm_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared opcodes, field positions and encodings
// for the GEMM instruction sequencer.
package gemm_pkg;

    localparam logic [3:0] OP_LD       = 4'b0010;
    localparam logic [3:0] OP_ST       = 4'b0011;
    localparam logic [3:0] OP_GEMM     = 4'b0100;
    localparam logic [3:0] OP_DRAINSYS = 4'b0101;

    localparam logic [3:0] CTRL_IDLE   = 4'd0;
    localparam logic [3:0] CTRL_STEADY = 4'd1;
    localparam logic [3:0] CTRL_DRAIN  = 4'd3;

    localparam int OPCODE_ARRAY_INDEX  = 12;
    localparam int BUF_ID_ARRAY_INDEX  = 10;
    localparam int MEM_LOC_ARRAY_INDEX = 0;

    localparam logic [1:0] BUF_LEFT = 2'd0;
    localparam logic [1:0] BUF_TOP  = 2'd1;
    localparam logic [1:0] BUF_DOWN = 2'd2;
    localparam logic [1:0] BUF_BAD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEMM,
        S_DRAIN,
        S_STORE
    } state_t;

endpackage

// File: rtl/gemm_sequencer_decode.sv
// Combinational split of an instruction into
// its fields plus one-hot op flags and an illegal flag.
module gemm_inst_decode
    import gemm_pkg::*;
#(
    parameter int INST_WIDTH = 16
) (
    input  logic [INST_WIDTH-1:0] inst,
    output logic [1:0]            buf_id,
    output logic [9:0]            mem_loc,
    output logic                  is_ld,
    output logic                  is_st,
    output logic                  is_gemm,
    output logic                  is_drain,
    output logic                  illegal
);

    logic [3:0] opcode;

    assign opcode   = inst[OPCODE_ARRAY_INDEX +: 4];
    assign buf_id   = inst[BUF_ID_ARRAY_INDEX +: 2];
    assign mem_loc  = inst[MEM_LOC_ARRAY_INDEX +: 10];

    assign is_ld    = (opcode == OP_LD) && (buf_id != BUF_BAD);
    assign is_st    = (opcode == OP_ST);
    assign is_gemm  = (opcode == OP_GEMM);
    assign is_drain = (opcode == OP_DRAINSYS);
    assign illegal  = !(is_ld || is_st || is_gemm || is_drain);

endmodule

// File: rtl/gemm_sequencer.sv
// Instruction-driven controller that sequences the
// systolic array: windows, ctrl_state and down readout.
module gemm_sequencer
    import gemm_pkg::*;
#(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int CTRL_WIDTH           = 4,
    parameter int INST_WIDTH           = 16,
    parameter int DRAIN_CYCLES         = NUM_ROW + 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_inst_valid,
    input  logic [INST_WIDTH-1:0]           i_inst,
    output logic                            o_inst_ready,
    output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_start,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_end,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_start,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_end,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_start,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_end,
    output logic                            o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_addr,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err
);

    localparam int AW    = LOG2_SRAM_BANK_DEPTH;
    localparam int CNT_W = $clog2((2**AW) + NUM_ROW + NUM_COL + DRAIN_CYCLES + 1);

    state_t                state, state_n;
    logic [CTRL_WIDTH-1:0] ctrl_n;
    logic [AW-1:0]         ls_n, le_n, ts_n, te_n, ds_n, de_n;
    logic                  rd_en_n, busy_n, done_n, err_n, ready_n;
    logic [AW-1:0]         rd_addr_n;
    logic [CNT_W-1:0]      cnt, cnt_n;

    logic [1:0]            buf_id;
    logic [9:0]            mem_loc;
    logic                  is_ld, is_st, is_gemm, is_drain, illegal;
    logic [AW-1:0]         win_lo, win_hi, left_len;
    logic [CNT_W-1:0]      gemm_m1;

    gemm_inst_decode #(
        .INST_WIDTH(INST_WIDTH)
    ) u_dec (
        .inst     (i_inst),
        .buf_id   (buf_id),
        .mem_loc  (mem_loc),
        .is_ld    (is_ld),
        .is_st    (is_st),
        .is_gemm  (is_gemm),
        .is_drain (is_drain),
        .illegal  (illegal)
    );

    assign win_lo   = mem_loc[AW-1:0];
    assign win_hi   = mem_loc[2*AW-1:AW];
    assign left_len = o_left_rd_end - o_left_rd_start + 1'b1;
    // A zero-length window wraps to the full bank, hence the extra MSB.
    assign gemm_m1  = CNT_W'({left_len == '0, left_len})
                    + CNT_W'(NUM_ROW + NUM_COL - 2);

    always_comb begin
        state_n   = state;
        ctrl_n    = o_ctrl_state;
        ls_n      = o_left_rd_start;
        le_n      = o_left_rd_end;
        ts_n      = o_top_rd_start;
        te_n      = o_top_rd_end;
        ds_n      = o_down_rd_start;
        de_n      = o_down_rd_end;
        rd_en_n   = o_down_rd_en;
        rd_addr_n = o_down_rd_addr;
        err_n     = o_err;
        done_n    = 1'b0;
        cnt_n     = cnt;
        unique case (state)
            S_IDLE: begin
                if (i_inst_valid) begin
                    if (illegal) err_n = 1'b1;
                    unique case (1'b1)
                        is_ld: begin
                            case (buf_id)
                                BUF_LEFT: begin ls_n = win_lo; le_n = win_hi; end
                                BUF_TOP:  begin ts_n = win_lo; te_n = win_hi; end
                                BUF_DOWN: begin ds_n = win_lo; de_n = win_hi; end
                                default:  ;
                            endcase
                        end
                        is_gemm: begin
                            state_n = S_GEMM;
                            ctrl_n  = CTRL_WIDTH'(CTRL_STEADY);
                            cnt_n   = gemm_m1;
                        end
                        is_drain: begin
                            state_n = S_DRAIN;
                            ctrl_n  = CTRL_WIDTH'(CTRL_DRAIN);
                            cnt_n   = CNT_W'(DRAIN_CYCLES - 1);
                        end
                        is_st: begin
                            state_n   = S_STORE;
                            rd_en_n   = 1'b1;
                            rd_addr_n = o_down_rd_start;
                        end
                        default: ;
                    endcase
                end
            end
            S_GEMM, S_DRAIN: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    ctrl_n  = CTRL_WIDTH'(CTRL_IDLE);
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_STORE: begin
                if (o_down_rd_addr == o_down_rd_end) begin
                    state_n = S_IDLE;
                    rd_en_n = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    rd_addr_n = o_down_rd_addr + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n  = (state_n != S_IDLE);
        ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            o_ctrl_state    <= CTRL_WIDTH'(CTRL_IDLE);
            o_left_rd_start <= '0;
            o_left_rd_end   <= '0;
            o_top_rd_start  <= '0;
            o_top_rd_end    <= '0;
            o_down_rd_start <= '0;
            o_down_rd_end   <= '0;
            o_down_rd_en    <= 1'b0;
            o_down_rd_addr  <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            o_inst_ready    <= 1'b1;
            cnt             <= '0;
        end else begin
            state           <= state_n;
            o_ctrl_state    <= ctrl_n;
            o_left_rd_start <= ls_n;
            o_left_rd_end   <= le_n;
            o_top_rd_start  <= ts_n;
            o_top_rd_end    <= te_n;
            o_down_rd_start <= ds_n;
            o_down_rd_end   <= de_n;
            o_down_rd_en    <= rd_en_n;
            o_down_rd_addr  <= rd_addr_n;
            o_busy          <= busy_n;
            o_done          <= done_n;
            o_err           <= err_n;
            o_inst_ready    <= ready_n;
            cnt             <= cnt_n;
        end
    end

endmodule
